// File: rtl/mc_control_fsm_if.sv
// Control-sequencer bundle: fetch port, data-memory port, decoder feedback and datapath strobes.
// master = sequencer side, slave = datapath/memory side.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
) ();
    logic             start;
    logic             imem_req;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic [5:0]       opcode;
    logic             zero;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             rf_we;
    logic             rf_wsel;
    logic             wb_sel;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             busy;
    logic             halted;
    logic             err_illegal;
    logic             err_timeout;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  start, imem_ack, imem_rdata, opcode, zero, dmem_ack,
        output imem_req, ir, dmem_req, dmem_we, alu_src, alu_op, rf_we, rf_wsel,
               wb_sel, pc_we, pc_src, busy, halted, err_illegal, err_timeout, retired_cnt
    );

    modport slave (
        output start, imem_ack, imem_rdata, opcode, zero, dmem_ack,
        input  imem_req, ir, dmem_req, dmem_we, alu_src, alu_op, rf_we, rf_wsel,
               wb_sel, pc_we, pc_src, busy, halted, err_illegal, err_timeout, retired_cnt
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; MC_PERF_CNT_EN adds a retired-instruction counter.
// Latency 2 (J) to 5 (LW) cycles, plus one per cycle of ack delay.
// Backpressure: imem/dmem requests hold until ack; a request unanswered for MEM_TIMEOUT cycles halts.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    mc_control_fsm_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int              TO_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nxt, end_nxt;
    logic [31:0]     ir_q;
    logic [TO_W-1:0] to_cnt;
    logic            err_illegal_q, err_timeout_q;
    logic            wait_ack, to_hit;
    logic            is_r, is_addi, is_andi, is_lw, is_sw, is_beq, is_j, is_legal;

    assign is_r     = (bus.opcode == 6'b000000);
    assign is_addi  = (bus.opcode == 6'b001000);
    assign is_andi  = (bus.opcode == 6'b001100);
    assign is_lw    = (bus.opcode == 6'b100011);
    assign is_sw    = (bus.opcode == 6'b101011);
    assign is_beq   = (bus.opcode == 6'b000100);
    assign is_j     = (bus.opcode == 6'b000010);
    assign is_legal = is_r | is_addi | is_andi | is_lw | is_sw | is_beq | is_j;

    assign wait_ack = ((state == S_FETCH) && !bus.imem_ack) || ((state == S_MEM) && !bus.dmem_ack);
    assign to_hit   = (MEM_TIMEOUT != 0) && wait_ack && (to_cnt == TO_LIMIT);
    assign end_nxt  = bus.start ? S_FETCH : S_IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FETCH;
            S_FETCH:  if (bus.imem_ack) state_nxt = S_DECODE;
                      else if (to_hit) state_nxt = S_HALT;
            S_DECODE: if (is_j) state_nxt = end_nxt;
                      else if (!is_legal) state_nxt = S_HALT;
                      else state_nxt = S_EXEC;
            S_EXEC:   if (is_beq) state_nxt = end_nxt;
                      else if (is_lw || is_sw) state_nxt = S_MEM;
                      else state_nxt = S_WB;
            S_MEM:    if (bus.dmem_ack) state_nxt = is_lw ? S_WB : end_nxt;
                      else if (to_hit) state_nxt = S_HALT;
            S_WB:     state_nxt = end_nxt;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.alu_src  = 1'b0;
        bus.alu_op   = 2'b00;
        bus.rf_we    = 1'b0;
        bus.rf_wsel  = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 2'b00;
        bus.busy     = (state != S_IDLE) && (state != S_HALT);
        bus.halted   = (state == S_HALT);
        case (state)
            S_FETCH: bus.imem_req = 1'b1;
            S_DECODE: if (is_j) begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 2'b10;
            end
            S_EXEC: begin
                bus.alu_src = ~(is_r | is_beq);
                if (is_r)        bus.alu_op = 2'b10;
                else if (is_beq) bus.alu_op = 2'b01;
                else if (is_andi) bus.alu_op = 2'b11;
                if (is_beq) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_src = bus.zero ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = is_sw;
                bus.pc_we    = is_sw && bus.dmem_ack;
            end
            S_WB: begin
                bus.rf_we   = 1'b1;
                bus.rf_wsel = is_r;
                bus.wb_sel  = is_lw;
                bus.pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Timeout counter restarts on every entry into a request state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q          <= '0;
            to_cnt        <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if ((state == S_FETCH) && bus.imem_ack) ir_q <= bus.imem_rdata;
            if (((state_nxt == S_FETCH) || (state_nxt == S_MEM)) && (state_nxt != state))
                to_cnt <= '0;
            else if (wait_ack)
                to_cnt <= to_cnt + 1'b1;
            if ((state == S_DECODE) && !is_legal) err_illegal_q <= 1'b1;
            if (to_hit) err_timeout_q <= 1'b1;
        end
    end

    assign bus.ir          = ir_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_timeout = err_timeout_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    always_ff @(posedge clk) begin
        if (rst)            retired_q <= '0;
        else if (bus.pc_we) retired_q <= retired_q + 1'b1;
    end
    assign bus.retired_cnt = retired_q;
`else
    assign bus.retired_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm: per-cycle strobe vectors with hand-computed expectations.
module tb_mc_control_fsm;
    logic clk;
    logic rst;

    mc_control_fsm_if #(.CNT_W(32)) bus ();

    mc_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.opcode = bus.ir[31:26];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_RT   = 32'h00681011;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_ANDI = 32'h30304032;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_SW   = 32'hAC220008;

    // {imem_req, dmem_req, dmem_we, alu_src, alu_op, rf_we, rf_wsel, wb_sel, pc_we, pc_src, busy, halted}
    localparam logic [13:0] E_IDLE   = 14'b0_0_0_0_00_0_0_0_0_00_0_0;
    localparam logic [13:0] E_FETCH  = 14'b1_0_0_0_00_0_0_0_0_00_1_0;
    localparam logic [13:0] E_DEC    = 14'b0_0_0_0_00_0_0_0_0_00_1_0;
    localparam logic [13:0] E_HALT   = 14'b0_0_0_0_00_0_0_0_0_00_0_1;
    localparam logic [13:0] E_EX_R   = 14'b0_0_0_0_10_0_0_0_0_00_1_0;
    localparam logic [13:0] E_EX_I   = 14'b0_0_0_1_00_0_0_0_0_00_1_0;
    localparam logic [13:0] E_EX_AND = 14'b0_0_0_1_11_0_0_0_0_00_1_0;
    localparam logic [13:0] E_WB_R   = 14'b0_0_0_0_00_1_1_0_1_00_1_0;
    localparam logic [13:0] E_WB_I   = 14'b0_0_0_0_00_1_0_0_1_00_1_0;
    localparam logic [13:0] E_WB_LW  = 14'b0_0_0_0_00_1_0_1_1_00_1_0;
    localparam logic [13:0] E_MEM_RD = 14'b0_1_0_0_00_0_0_0_0_00_1_0;
    localparam logic [13:0] E_SW_ACK = 14'b0_1_1_0_00_0_0_0_1_00_1_0;
    localparam logic [13:0] E_BEQ_T  = 14'b0_0_0_0_01_0_0_0_1_01_1_0;
    localparam logic [13:0] E_BEQ_N  = 14'b0_0_0_0_01_0_0_0_1_00_1_0;
    localparam logic [13:0] E_J      = 14'b0_0_0_0_00_0_0_0_1_10_1_0;

`ifdef MC_PERF_CNT_EN
    localparam logic [31:0] EXP_RETIRED = 32'd3;
`else
    localparam logic [31:0] EXP_RETIRED = 32'd0;
`endif

    typedef struct packed {
        logic        start;
        logic        iack;
        logic        dack;
        logic        zero;
        logic [31:0] rdata;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] strobes();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.alu_src, bus.alu_op, bus.rf_we,
                bus.rf_wsel, bus.wb_sel, bus.pc_we, bus.pc_src, bus.busy, bus.halted};
    endfunction

    task automatic apply(input vec_t v);
        bus.start      = v.start;
        bus.imem_ack   = v.iack;
        bus.dmem_ack   = v.dack;
        bus.zero       = v.zero;
        bus.imem_rdata = v.rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 14'h0});
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply('{1'b1, 1'b1, 1'b1, 1'b1, I_RT, 14'h0});
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_IDLE) begin n_fail++; $display("FAIL reset_strobes: got %b want %b", strobes(), E_IDLE); end
        n_checks++;
        if (bus.ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", bus.ir); end
        n_checks++;
        if ({bus.err_illegal, bus.err_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {bus.err_illegal, bus.err_timeout}); end
        n_checks++;
        if (bus.retired_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired_cnt); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        vec_t v [6];
        do_reset();
        v = '{'{1'b1, 1'b0, 1'b0, 1'b0, I_RT, E_IDLE},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_RT, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_RT, E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_RT, E_EX_R},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_RT, E_WB_R},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_RT, E_IDLE}};
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++;
            if (strobes() !== v[i].exp) begin n_fail++; $display("FAIL rtype_cyc%0d: got %b want %b", i, strobes(), v[i].exp); end
            next_cycle();
        end
        n_checks++;
        if (bus.ir !== I_RT) begin n_fail++; $display("FAIL rtype_ir: got %h want %h", bus.ir, I_RT); end
    endtask

    task automatic test_lw_wait();
        vec_t v [10];
        do_reset();
        v = '{'{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_IDLE},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_LW, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_EX_I},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_MEM_RD},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_MEM_RD},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_LW, E_MEM_RD},
              '{1'b1, 1'b0, 1'b1, 1'b0, I_LW, E_MEM_RD},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_LW, E_WB_LW},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_LW, E_IDLE}};
        for (int i = 0; i < 10; i++) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++;
            if (strobes() !== v[i].exp) begin n_fail++; $display("FAIL lw_cyc%0d: got %b want %b", i, strobes(), v[i].exp); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [8];
        do_reset();
        v = '{'{1'b1, 1'b0, 1'b0, 1'b0, I_BEQ, E_IDLE},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_BEQ, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_BEQ, E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b1, I_BEQ, E_BEQ_T},
              '{1'b1, 1'b1, 1'b0, 1'b1, I_BEQ, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b1, I_BEQ, E_DEC},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_BEQ, E_BEQ_N},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_BEQ, E_IDLE}};
        for (int i = 0; i < 8; i++) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++;
            if (strobes() !== v[i].exp) begin n_fail++; $display("FAIL beq_cyc%0d: got %b want %b", i, strobes(), v[i].exp); end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        vec_t v [5];
        do_reset();
        v = '{'{1'b1, 1'b0, 1'b0, 1'b0, I_ILL, E_IDLE},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_ILL, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_ILL, E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_ILL, E_HALT},
              '{1'b1, 1'b1, 1'b1, 1'b0, I_RT,  E_HALT}};
        for (int i = 0; i < 5; i++) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++;
            if (strobes() !== v[i].exp) begin n_fail++; $display("FAIL illegal_cyc%0d: got %b want %b", i, strobes(), v[i].exp); end
            next_cycle();
        end
        n_checks++;
        if ({bus.err_illegal, bus.err_timeout} !== 2'b10) begin n_fail++; $display("FAIL illegal_err: got %b want 10", {bus.err_illegal, bus.err_timeout}); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.err_illegal, bus.halted, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL illegal_clear: got %b want 000", {bus.err_illegal, bus.halted, bus.busy}); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        apply('{1'b1, 1'b0, 1'b0, 1'b0, I_RT, 14'h0});
        next_cycle();
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (strobes() !== E_FETCH) begin n_fail++; $display("FAIL timeout_req%0d: got %b want %b", i, strobes(), E_FETCH); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_HALT) begin n_fail++; $display("FAIL timeout_halt: got %b want %b", strobes(), E_HALT); end
        n_checks++;
        if ({bus.err_illegal, bus.err_timeout} !== 2'b01) begin n_fail++; $display("FAIL timeout_err: got %b want 01", {bus.err_illegal, bus.err_timeout}); end
        next_cycle();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_HALT) begin n_fail++; $display("FAIL timeout_absorb: got %b want %b", strobes(), E_HALT); end
        next_cycle();
    endtask

    task automatic test_timeout_edge();
        do_reset();
        apply('{1'b1, 1'b0, 1'b0, 1'b0, I_RT, 14'h0});
        next_cycle();
        for (int i = 1; i <= 14; i++) next_cycle();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_FETCH) begin n_fail++; $display("FAIL limit_fetch: got %b want %b", strobes(), E_FETCH); end
        next_cycle();
        bus.imem_ack = 1'b0;
        bus.start    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_DEC) begin n_fail++; $display("FAIL limit_decode: got %b want %b", strobes(), E_DEC); end
        n_checks++;
        if ({bus.err_timeout, bus.ir} !== {1'b0, I_RT}) begin n_fail++; $display("FAIL limit_err_ir: got %b/%h want 0/%h", bus.err_timeout, bus.ir, I_RT); end
        next_cycle();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        apply('{1'b1, 1'b0, 1'b0, 1'b0, I_RT, 14'h0});
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rstfetch_before: got %b want 1", bus.imem_req); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (strobes() !== E_IDLE) begin n_fail++; $display("FAIL rstfetch_after: got %b want %b", strobes(), E_IDLE); end
        next_cycle();
    endtask

    task automatic test_perf_cnt();
        vec_t v [12];
        do_reset();
        v = '{'{1'b1, 1'b0, 1'b0, 1'b0, I_ANDI, E_IDLE},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_ANDI, E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_ANDI, E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_ANDI, E_EX_AND},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_ANDI, E_WB_I},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_J,    E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_J,    E_J},
              '{1'b1, 1'b1, 1'b0, 1'b0, I_SW,   E_FETCH},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_SW,   E_DEC},
              '{1'b1, 1'b0, 1'b0, 1'b0, I_SW,   E_EX_I},
              '{1'b0, 1'b0, 1'b1, 1'b0, I_SW,   E_SW_ACK},
              '{1'b0, 1'b0, 1'b0, 1'b0, I_SW,   E_IDLE}};
        for (int i = 0; i < 12; i++) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++;
            if (strobes() !== v[i].exp) begin n_fail++; $display("FAIL perf_cyc%0d: got %b want %b", i, strobes(), v[i].exp); end
            next_cycle();
        end
        n_checks++;
        if (bus.retired_cnt !== EXP_RETIRED) begin n_fail++; $display("FAIL perf_retired: got %0d want %0d", bus.retired_cnt, EXP_RETIRED); end
    endtask

    initial begin
        rst = 1'b1;
        apply('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 14'h0});
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_fetch();
        test_perf_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
